// File: rtl/fpu_pkg.sv
// fpu_pkg: shared FPU types and helpers (multiplier state encoding, wide two's-complement negate)
package fpu_pkg;
    localparam int MAX_W = 128;
    typedef enum logic [1:0] {MUL_IDLE = 2'd0, MUL_RUN = 2'd1, MUL_FIX = 2'd2} mul_state_t;
    // Negate x modulo 2^w; callers size-cast the result back to their own width.
    function automatic logic [MAX_W-1:0] twos_neg(input logic [MAX_W-1:0] x, input int w);
        logic [MAX_W-1:0] m;
        m = (w >= MAX_W) ? '1 : (MAX_W'(1) << w) - MAX_W'(1);
        return (~x + MAX_W'(1)) & m;
    endfunction
endpackage

// File: rtl/seq_mult_datapath.sv
// seq_mult_datapath: acc/mcand/mplier registers with the shift-add step and final sign fix-up
module seq_mult_datapath
    import fpu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 step,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    output logic                 rest_zero,
    output logic [2*WIDTH-1:0]   result
);
    logic [2*WIDTH-1:0] acc, mcand, acc_nxt;
    logic [WIDTH-1:0]   mplier, mag_a, mag_b;
    logic               neg;
    always_comb begin
        mag_a     = (is_signed && op_a[WIDTH-1]) ? WIDTH'(twos_neg(MAX_W'(op_a), WIDTH)) : op_a;
        mag_b     = (is_signed && op_b[WIDTH-1]) ? WIDTH'(twos_neg(MAX_W'(op_b), WIDTH)) : op_b;
        acc_nxt   = acc + (mplier[0] ? mcand : '0);
        result    = neg ? (2*WIDTH)'(twos_neg(MAX_W'(acc_nxt), 2*WIDTH)) : acc_nxt;
        rest_zero = (mplier >> 1) == '0;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            neg    <= 1'b0;
        end else if (load) begin
            acc    <= '0;
            mcand  <= (2*WIDTH)'(mag_a);
            mplier <= mag_b;
            neg    <= is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
        end else if (step) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end
endmodule

// File: rtl/seq_shift_add_mult.sv
// seq_shift_add_mult: iterative shift-add multiplier with start/busy/done handshake.
// Define SEQ_MULT_EARLY_TERM_EN to finish as soon as the remaining multiplier bits are zero.
module seq_shift_add_mult
    import fpu_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    mul_state_t         state;
    logic [CNT_W-1:0]   cnt;
    logic               load, step, last, rest_zero;
    logic [2*WIDTH-1:0] result;
    assign load = (state == MUL_IDLE) && start;
    assign step = (state == MUL_RUN);
`ifdef SEQ_MULT_EARLY_TERM_EN
    assign last = (cnt == CNT_W'(WIDTH - 1)) || rest_zero;
`else
    assign last = (cnt == CNT_W'(WIDTH - 1));
`endif
    seq_mult_datapath #(.WIDTH(WIDTH)) u_dp (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .step      (step),
        .is_signed (is_signed),
        .op_a      (op_a),
        .op_b      (op_b),
        .rest_zero (rest_zero),
        .result    (result)
    );
    // Outputs are registered on the final RUN edge so the FIX cycle already shows done and product.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= MUL_IDLE;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                MUL_IDLE: if (start) begin
                    state <= MUL_RUN;
                    cnt   <= '0;
                    busy  <= 1'b1;
                end
                MUL_RUN: begin
                    cnt <= cnt + CNT_W'(1);
                    if (last) begin
                        state   <= MUL_FIX;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        product <= result;
                    end
                end
                MUL_FIX: state <= MUL_IDLE;
                default: state <= MUL_IDLE;
            endcase
        end
    end
endmodule
